bpsk_symbol_scheduler: RTL

Frame sequencer for the BPSK modulator datapath. It generates the `lfsr` data bit that selects +sin / -sin in the modulator, and holds each bit for a programmable number of sample strobes. Each frame is a start pulse, then an alternating preamble, then a PRBS15 payload, then done. The Nios control registers drive the cfg/start/stop inputs; the DDS sample strobe paces symbol timing.

---
 rtl/bpsk_symbol_scheduler.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/bpsk_symbol_scheduler.sv
// Frame sequencer for the BPSK modulator: emits the data bit (lfsr) selecting +sin/-sin.
// Latency: first frame bit is registered and appears one clk after start is accepted.
// Backpressure: none; symbol pacing follows sample_en, stop aborts at the next symbol boundary.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   start, stop                  one-cycle frame request / abort request
//   sample_en                    DDS sample-rate strobe; each bit lasts sps strobes
//   cfg_sps, cfg_pre_len,
//   cfg_payload_len              frame configuration, latched when start is accepted
//   lfsr                         data bit to modulator (1 = +sin); 1 while idle
//   sym_tick                     one-cycle pulse after each symbol boundary in a frame
//   busy, done                   frame in progress / normal-completion pulse
//   bit_count                    symbols completed in the current phase
//
// Optional build macro BPSK_SCHED_DIFF_EN: differentially encode payload bits (DBPSK).
module bpsk_symbol_scheduler #(
  parameter int          CNT_W     = 16,
  parameter int          LEN_W     = 16,
  parameter logic [14:0] LFSR_SEED = 15'h7FFF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             sample_en,
  input  logic [CNT_W-1:0] cfg_sps,
  input  logic [LEN_W-1:0] cfg_pre_len,
  input  logic [LEN_W-1:0] cfg_payload_len,
  output logic             lfsr,
  output logic             sym_tick,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] bit_count
);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_PAY} state_t;

  // An all-zero PRBS15 state would lock up, so it is replaced by 1.
  localparam logic [14:0]      SEED    = (LFSR_SEED == 15'd0) ? 15'd1 : LFSR_SEED;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [LEN_W-1:0] LEN_ONE = 1;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] sps_q;
  logic [LEN_W-1:0] pre_len_q;
  logic [LEN_W-1:0] pay_len_q;
  logic [LEN_W-1:0] bit_cnt_q;
  logic [14:0]      prbs_q;
  logic             lfsr_q;
  logic             tick_q;
  logic             busy_q;
  logic             done_q;
  logic             stop_pend_q;

  logic boundary;
  logic phase_last;
  logic frame_last;
  logic abort_now;
  logic pay_first_bit;
  logic pay_next_bit;

  assign boundary   = sample_en && (cnt_q == sps_q - CNT_ONE);
  assign phase_last = (state_q == S_PRE) ? (bit_cnt_q == pre_len_q - LEN_ONE)
                                         : (bit_cnt_q == pay_len_q - LEN_ONE);
  // Last symbol of the whole frame: end of payload, or end of preamble with no payload.
  assign frame_last = phase_last && ((state_q == S_PAY) || (pay_len_q == '0));
  // A stop arriving on the boundary cycle itself counts as pending for that boundary.
  assign abort_now  = stop_pend_q || stop;

  // The PRBS register still holds the seed when the payload begins, so d_0 is SEED[14].
  // lfsr_q is 1 in IDLE and holds the last preamble bit at the preamble/payload switch,
  // which is exactly the encoder history e_(-1).
`ifdef BPSK_SCHED_DIFF_EN
  assign pay_first_bit = lfsr_q ^ SEED[14];
  assign pay_next_bit  = lfsr_q ^ prbs_q[13];
`else
  assign pay_first_bit = SEED[14];
  assign pay_next_bit  = prbs_q[13];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sps_q       <= CNT_ONE;
      pre_len_q   <= '0;
      pay_len_q   <= '0;
      bit_cnt_q   <= '0;
      prbs_q      <= SEED;
      lfsr_q      <= 1'b1;
      tick_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          lfsr_q      <= 1'b1;
          busy_q      <= 1'b0;
          bit_cnt_q   <= '0;
          cnt_q       <= '0;
          stop_pend_q <= 1'b0;
          if (start) begin
            sps_q     <= (cfg_sps == '0) ? CNT_ONE : cfg_sps;
            pre_len_q <= cfg_pre_len;
            pay_len_q <= cfg_payload_len;
            prbs_q    <= SEED;
            if (cfg_pre_len != '0) begin
              state_q <= S_PRE;
              busy_q  <= 1'b1;
              lfsr_q  <= 1'b1;
            end else if (cfg_payload_len != '0) begin
              state_q <= S_PAY;
              busy_q  <= 1'b1;
              lfsr_q  <= pay_first_bit;
            end else begin
              done_q  <= 1'b1;
            end
          end
        end

        S_PRE, S_PAY: begin
          if (stop) stop_pend_q <= 1'b1;
          if (sample_en) begin
            if (!boundary) begin
              cnt_q <= cnt_q + CNT_ONE;
            end else begin
              cnt_q  <= '0;
              tick_q <= 1'b1;
              if (frame_last || abort_now) begin
                // Normal completion wins over a coincident stop.
                state_q     <= S_IDLE;
                done_q      <= frame_last;
                busy_q      <= 1'b0;
                lfsr_q      <= 1'b1;
                bit_cnt_q   <= '0;
                stop_pend_q <= 1'b0;
              end else if (phase_last) begin
                state_q   <= S_PAY;
                bit_cnt_q <= '0;
                lfsr_q    <= pay_first_bit;
              end else begin
                bit_cnt_q <= bit_cnt_q + LEN_ONE;
                if (state_q == S_PRE) begin
                  lfsr_q <= ~lfsr_q;
                end else begin
                  prbs_q <= {prbs_q[13:0], prbs_q[14] ^ prbs_q[13]};
                  lfsr_q <= pay_next_bit;
                end
              end
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign lfsr      = lfsr_q;
  assign sym_tick  = tick_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign bit_count = bit_cnt_q;

endmodule
